// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of a combinational 8-bit ALU, with a registered valid/ready result stage.
// Optional result flags (res_zero_o, res_carry_o) are built when ALU_QUEUE_FLAGS_EN is defined.
module alu_cmd_queue #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] cmd_a_i,
  input  logic [7:0] cmd_b_i,
  input  logic [2:0] cmd_op_i,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  output logic [2:0] alu_op_o,
  input  logic [7:0] alu_res_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic [7:0] res_data_o,
  output logic [2:0] res_op_o
`ifdef ALU_QUEUE_FLAGS_EN
  ,
  output logic       res_zero_o,
  output logic       res_carry_o
`endif
);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_cmd_queue: DEPTH must be a power of two and at least 2");
  end

  cmd_t          mem_q [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [2:0]    res_op_q, res_op_d;
  logic          push, pop, empty;

`ifdef ALU_QUEUE_FLAGS_EN
  logic       res_zero_q, res_zero_d;
  logic       res_carry_q, res_carry_d;
  logic [8:0] add_sum;
  logic       carry_now;
`endif

  assign empty       = (count_q == '0);
  assign cmd_ready_o = (count_q != FULL_COUNT);
  assign push        = cmd_valid_i & cmd_ready_o;
  assign pop         = ~empty & (~res_valid_q | res_ready_i);
  assign head        = mem_q[rd_ptr_q];

  // The ALU sees zeros rather than stale storage while the queue is empty.
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = '0;
    if (!empty) begin
      alu_a_o  = head.a;
      alu_b_o  = head.b;
      alu_op_o = head.op;
    end
  end

`ifdef ALU_QUEUE_FLAGS_EN
  assign add_sum = {1'b0, alu_a_o} + {1'b0, alu_b_o};

  always_comb begin
    carry_now = 1'b0;
    case (alu_op_o)
      3'b000:  carry_now = add_sum[8];
      3'b001:  carry_now = (alu_a_o < alu_b_o);
      default: carry_now = 1'b0;
    endcase
  end
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
`ifdef ALU_QUEUE_FLAGS_EN
    res_zero_d  = res_zero_q;
    res_carry_d = res_carry_q;
`endif
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    // A consumed result with nothing to replace it leaves data/op holding their last values.
    if (pop) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_res_i;
      res_op_d    = alu_op_o;
`ifdef ALU_QUEUE_FLAGS_EN
      res_zero_d  = (alu_res_i == 8'h00);
      res_carry_d = carry_now;
`endif
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
`ifdef ALU_QUEUE_FLAGS_EN
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
`ifdef ALU_QUEUE_FLAGS_EN
      res_zero_q  <= res_zero_d;
      res_carry_q <= res_carry_d;
`endif
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: cmd_a_i, b: cmd_b_i, op: cmd_op_i};
  end

  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_op_o    = res_op_q;
`ifdef ALU_QUEUE_FLAGS_EN
  assign res_zero_o  = res_zero_q;
  assign res_carry_o = res_carry_q;
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: hand-derived vector table, corner sequences and a
// randomized stream scored against a queue-based reference model (flags when ALU_QUEUE_FLAGS_EN).
module tb_alu_cmd_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef struct {
    bit         cv;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    bit         rr;
    bit         exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_op;
    bit         exp_ready;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_op;
`ifdef ALU_QUEUE_FLAGS_EN
  logic       res_zero, res_carry;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  cmd_t       mq[$];
  bit         m_valid;
  logic [7:0] m_data;
  logic [2:0] m_op;
  bit         m_zero, m_carry;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  alu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .cmd_op_i    (cmd_op),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_res_i   (alu_res),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_op_o    (res_op)
`ifdef ALU_QUEUE_FLAGS_EN
    ,
    .res_zero_o  (res_zero),
    .res_carry_o (res_carry)
`endif
  );

  // Stand-in for the combinational ALU that sits downstream of the queue.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a << b[2:0];
      3'd3:    return a >> b[2:0];
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return {7'b0, a == b};
    endcase
  endfunction

  function automatic bit carry_f(input cmd_t c);
    int sum;
    sum = int'(c.a) + int'(c.b);
    if (c.op == 3'd0) return sum > 255;
    if (c.op == 3'd1) return c.a < c.b;
    return 1'b0;
  endfunction

  assign alu_res = alu_f(alu_a, alu_b, alu_op);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    mq.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_op    = '0;
    m_zero  = 1'b0;
    m_carry = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, check pre-edge outputs, advance model across one rising edge.
  task automatic applyStimulus(input bit cv, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op, input bit rr, output bit accepted);
    bit   m_ready, m_pop;
    cmd_t h;
    cmd_valid = cv;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    res_ready = rr;
    #1;
    m_ready = (mq.size() != DEPTH);
    checkOutput("cmd_ready_pre", 32'(cmd_ready), 32'(m_ready));
    if (mq.size() != 0) h = mq[0];
    else h = '0;
    checkOutput("alu_a", 32'(alu_a), 32'(h.a));
    checkOutput("alu_b", 32'(alu_b), 32'(h.b));
    checkOutput("alu_op", 32'(alu_op), 32'(h.op));
    accepted = cv && m_ready;
    m_pop    = (mq.size() != 0) && (!m_valid || rr);
    if (res_valid && rr) got.push_back(res_data);
    @(posedge clk);
    if (m_pop) begin
      h       = mq.pop_front();
      m_valid = 1'b1;
      m_data  = alu_f(h.a, h.b, h.op);
      m_op    = h.op;
      m_zero  = (m_data == 8'h00);
      m_carry = carry_f(h);
    end else if (rr) begin
      m_valid = 1'b0;
    end
    if (accepted) mq.push_back('{a: a, b: b, op: op});
    @(negedge clk);
    checkOutput("res_valid", 32'(res_valid), 32'(m_valid));
    checkOutput("res_data", 32'(res_data), 32'(m_data));
    checkOutput("res_op", 32'(res_op), 32'(m_op));
`ifdef ALU_QUEUE_FLAGS_EN
    checkOutput("res_zero", 32'(res_zero), 32'(m_zero));
    checkOutput("res_carry", 32'(res_carry), 32'(m_carry));
`endif
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && (mq.size() != 0 || m_valid); i++)
      applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    checkOutput("drain_done", 32'(mq.size() != 0 || m_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[16];
    bit   acc;
    int   idx;
    int   lo;
    logic [7:0] ra;

    // Fill/backpressure scenario with every expectation worked out by hand.
    vecs[0]  = '{1'b1, 8'h05, 8'h03, 3'd0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 8'h08, 3'd0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 8'h08, 3'd0, 1'b1};
    vecs[3]  = '{1'b1, 8'h10, 8'h01, 3'd1, 1'b0, 1'b0, 8'h08, 3'd0, 1'b1};
    vecs[4]  = '{1'b1, 8'h03, 8'h02, 3'd2, 1'b0, 1'b1, 8'h0F, 3'd1, 1'b1};
    vecs[5]  = '{1'b1, 8'h80, 8'h03, 3'd3, 1'b0, 1'b1, 8'h0F, 3'd1, 1'b1};
    vecs[6]  = '{1'b1, 8'hF0, 8'h3C, 3'd4, 1'b0, 1'b1, 8'h0F, 3'd1, 1'b1};
    vecs[7]  = '{1'b1, 8'hF0, 8'h0F, 3'd5, 1'b0, 1'b1, 8'h0F, 3'd1, 1'b0};
    vecs[8]  = '{1'b1, 8'hAA, 8'h55, 3'd6, 1'b0, 1'b1, 8'h0F, 3'd1, 1'b0};
    vecs[9]  = '{1'b1, 8'hAA, 8'h55, 3'd6, 1'b1, 1'b1, 8'h0C, 3'd2, 1'b1};
    vecs[10] = '{1'b1, 8'hAA, 8'h55, 3'd6, 1'b1, 1'b1, 8'h10, 3'd3, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 8'h30, 3'd4, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 8'hFF, 3'd5, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 8'hFF, 3'd6, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 8'hFF, 3'd6, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 8'hFF, 3'd6, 1'b1};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    res_ready = 1'b0;
    resetModel();
    #12;
    checkOutput("rst_res_valid", 32'(res_valid), 32'(0));
    checkOutput("rst_res_data", 32'(res_data), 32'(0));
    checkOutput("rst_res_op", 32'(res_op), 32'(0));
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    checkOutput("rst_alu_a", 32'(alu_a), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].cv, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].rr, acc);
      checkOutput($sformatf("vec%0d_valid", i), 32'(res_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_data", i), 32'(res_data), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d_op", i), 32'(res_op), 32'(vecs[i].exp_op));
      checkOutput($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'(vecs[i].exp_ready));
    end

    // Simultaneous push and pop at count 2: one result held, two queued, then push while consuming.
    applyStimulus(1'b1, 8'h11, 8'h22, 3'd0, 1'b0, acc);
    applyStimulus(1'b1, 8'h33, 8'h44, 3'd6, 1'b0, acc);
    applyStimulus(1'b1, 8'h55, 8'h66, 3'd5, 1'b0, acc);
    checkOutput("simul_count_before", 32'(mq.size()), 32'(2));
    applyStimulus(1'b1, 8'h77, 8'h07, 3'd7, 1'b1, acc);
    checkOutput("simul_count_after", 32'(mq.size()), 32'(2));
    checkOutput("simul_data", 32'(res_data), 32'(8'h77));
    drain();

    // Reset with three commands queued and a result pending.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i + 1), 8'h01, 3'd0, 1'b0, acc);
    reset_n = 1'b0;
    #2;
    resetModel();
    checkOutput("midrst_res_valid", 32'(res_valid), 32'(0));
    checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'(1));
    checkOutput("midrst_res_data", 32'(res_data), 32'(0));
    checkOutput("midrst_alu_a", 32'(alu_a), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);

    // Ten eq commands, equal operands on even indices only, consumer randomly stalling.
    got.delete();
    idx = 0;
    for (int cyc = 0; cyc < 300 && (idx < 10 || got.size() < 10); cyc++) begin
      ra = 8'($urandom);
      lo = $urandom_range(1, 255);
      applyStimulus(idx < 10, ra, (idx % 2 == 0) ? ra : (ra ^ 8'(lo)), 3'd7, 1'($urandom), acc);
      if (acc) idx++;
    end
    checkOutput("wrap_count", 32'(got.size()), 32'(10));
    for (int i = 0; i < 10 && i < got.size(); i++)
      checkOutput($sformatf("wrap_res%0d", i), 32'(got[i]), 32'((i % 2 == 0) ? 1 : 0));
    drain();

    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0), acc);
    drain();

`ifdef ALU_QUEUE_FLAGS_EN
    applyStimulus(1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, acc);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, acc);
    checkOutput("flag_add_data", 32'(res_data), 32'(8'h00));
    checkOutput("flag_add_zero", 32'(res_zero), 32'(1));
    checkOutput("flag_add_carry", 32'(res_carry), 32'(1));
    applyStimulus(1'b1, 8'h02, 8'h05, 3'd1, 1'b0, acc);
    checkOutput("flag_hold_carry", 32'(res_carry), 32'(1));
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    checkOutput("flag_sub_data", 32'(res_data), 32'(8'hFD));
    checkOutput("flag_sub_zero", 32'(res_zero), 32'(0));
    checkOutput("flag_sub_carry", 32'(res_carry), 32'(1));
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
